// File: rtl/data_mem_responder.sv
// MEM-stage data-port responder: word RAM with a wait-state counter, a stall request,
// abort on ce drop and an address range check.
module data_mem_responder #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ready_o,
  output logic        err_o,
  output logic        stallreq_o
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CNT_W = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_d;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_d;
  logic             capture;
  logic             enter_resp;

  logic             we_q;
  logic [31:0]      addr_q;
  logic [3:0]       sel_q;
  logic [31:0]      data_q;

  logic [31:0]           mem [DEPTH];
  logic                  cur_we;
  logic [31:0]           cur_addr;
  logic                  cur_oor;
  logic [ADDR_WIDTH-1:0] cur_idx;
  logic                  oor_q;
  logic [ADDR_WIDTH-1:0] idx_q;

  // With no wait states the response is entered straight from IDLE, before the capture lands.
  assign cur_we   = (state == S_IDLE) ? we_i   : we_q;
  assign cur_addr = (state == S_IDLE) ? addr_i : addr_q;
  assign cur_oor  = (cur_addr >> (ADDR_WIDTH + 2)) != '0;
  assign cur_idx  = cur_addr[ADDR_WIDTH+1:2];
  assign oor_q    = (addr_q >> (ADDR_WIDTH + 2)) != '0;
  assign idx_q    = addr_q[ADDR_WIDTH+1:2];

  assign stallreq_o = ce_i & (state != S_RESP);

  // Next-state and wait counter
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    capture    = 1'b0;
    enter_resp = 1'b0;
    case (state)
      S_IDLE: begin
        if (ce_i) begin
          capture = 1'b1;
          cnt_d   = CNT_W'(WAIT_CYCLES);
          if (WAIT_CYCLES > 0) begin
            state_d = S_WAIT;
          end else begin
            state_d    = S_RESP;
            enter_resp = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (!ce_i) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt <= CNT_W'(1)) begin
          state_d    = S_RESP;
          enter_resp = 1'b1;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // Captured request; only this copy is used after accept
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      sel_q  <= '0;
      data_q <= '0;
    end else if (capture) begin
      we_q   <= we_i;
      addr_q <= addr_i;
      sel_q  <= sel_i;
      data_q <= data_i;
    end
  end

  // Response outputs, registered on entry to RESP
  always_ff @(posedge clk) begin
    if (rst) begin
      data_o  <= '0;
      ready_o <= 1'b0;
      err_o   <= 1'b0;
    end else begin
      ready_o <= enter_resp;
      err_o   <= enter_resp & cur_oor;
      if (enter_resp && cur_oor) begin
        data_o <= '0;
      end else if (enter_resp && !cur_we) begin
        data_o <= mem[cur_idx];
      end
    end
  end

  // Byte-lane write commits on the RESP edge; dropped if reset hits that edge
  always_ff @(posedge clk) begin
    if (!rst && state == S_RESP && we_q && !oor_q) begin
      for (int b = 0; b < 4; b++) begin
        if (sel_q[b]) begin
          mem[idx_q][8*b +: 8] <= data_q[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed vector table, reset corner cases and
// random accesses against a word-array reference model, on 1- and 3-wait-state instances.
module tb_data_mem_responder;

  localparam int unsigned AW = 10;

  typedef struct {
    int          d;
    bit          w;
    logic [31:0] a;
    logic [3:0]  s;
    logic [31:0] v;
    int          abort_at;
    bit          exp_err;
    bit          chk_data;
    logic [31:0] exp_d;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce   [2];
  logic        we   [2];
  logic [31:0] addr [2];
  logic [3:0]  sel  [2];
  logic [31:0] din  [2];
  logic [31:0] dout [2];
  logic        ready[2];
  logic        err  [2];
  logic        stall[2];

  int checks   = 0;
  int failures = 0;

  logic [31:0] mdl   [2][1024];
  bit          known [2][1024];
  vec_t        tbl[$];

  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(1)) u_dut0 (
    .clk(clk), .rst(rst), .ce_i(ce[0]), .we_i(we[0]), .addr_i(addr[0]),
    .sel_i(sel[0]), .data_i(din[0]), .data_o(dout[0]), .ready_o(ready[0]),
    .err_o(err[0]), .stallreq_o(stall[0])
  );

  data_mem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(3)) u_dut1 (
    .clk(clk), .rst(rst), .ce_i(ce[1]), .we_i(we[1]), .addr_i(addr[1]),
    .sel_i(sel[1]), .data_i(din[1]), .data_o(dout[1]), .ready_o(ready[1]),
    .err_o(err[1]), .stallreq_o(stall[1])
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // One access on instance d; response is due WAIT+1 cycles after the accept cycle.
  task automatic access(input int d, input bit w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] v, input int abort_at, input bit exp_err,
                        input bit chk_data, input logic [31:0] exp_d);
    int lat;
    int idx;
    lat = (d == 0) ? 1 : 3;
    idx = int'(a[AW+1:2]);
    for (int k = 0; k <= lat + 1; k++) begin
      @(negedge clk);
      if (k == 0) begin
        ce[1-d] = 1'b0;
        we[d] = w; addr[d] = a; sel[d] = s; din[d] = v; ce[d] = 1'b1;
      end else if (k == 1) begin
        we[d] = ~w; addr[d] = ~a; sel[d] = ~s; din[d] = ~v;
      end
      if (k == abort_at) ce[d] = 1'b0;
      #1;
      if (abort_at >= 0 && k >= abort_at) begin
        chk($sformatf("abort_ready%0d_k%0d", d, k), 32'(ready[d]), 32'd0);
        chk($sformatf("abort_err%0d_k%0d", d, k), 32'(err[d]), 32'd0);
      end else if (k <= lat) begin
        chk($sformatf("wait_ready%0d_k%0d", d, k), 32'(ready[d]), 32'd0);
        chk($sformatf("wait_stall%0d_k%0d", d, k), 32'(stall[d]), 32'd1);
      end else begin
        chk($sformatf("resp_ready%0d", d), 32'(ready[d]), 32'd1);
        chk($sformatf("resp_stall%0d", d), 32'(stall[d]), 32'd0);
        chk($sformatf("resp_err%0d_a%h", d, a), 32'(err[d]), 32'(exp_err));
        if (!w && chk_data) chk($sformatf("resp_data%0d_a%h", d, a), dout[d], exp_d);
      end
    end
    if (abort_at < 0 && w && !exp_err) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) mdl[d][idx][8*b +: 8] = v[8*b +: 8];
      if (s == 4'hF) known[d][idx] = 1'b1;
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      ce[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; sel[i] = '0; din[i] = '0;
      for (int j = 0; j < 1024; j++) begin
        mdl[i][j] = '0; known[i][j] = 1'b0;
      end
    end

    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_ready%0d", i), 32'(ready[i]), 32'd0);
      chk($sformatf("rst_err%0d", i), 32'(err[i]), 32'd0);
      chk($sformatf("rst_data%0d", i), dout[i], 32'd0);
      chk($sformatf("rst_stall%0d", i), 32'(stall[i]), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("idle_ready0", 32'(ready[0]), 32'd0);
    chk("idle_ready1", 32'(ready[1]), 32'd0);

    tbl.push_back('{0, 1'b1, 32'h10,   4'hF, 32'hDEADBEEF, -1, 1'b0, 1'b0, 32'h0});
    tbl.push_back('{0, 1'b0, 32'h10,   4'hF, 32'h0,        -1, 1'b0, 1'b1, 32'hDEADBEEF});
    tbl.push_back('{0, 1'b1, 32'h10,   4'h4, 32'h55555555, -1, 1'b0, 1'b0, 32'h0});
    tbl.push_back('{0, 1'b0, 32'h10,   4'h0, 32'h0,        -1, 1'b0, 1'b1, 32'hDE55BEEF});
    tbl.push_back('{0, 1'b1, 32'h10,   4'h0, 32'h0,        -1, 1'b0, 1'b0, 32'h0});
    tbl.push_back('{0, 1'b0, 32'h10,   4'hF, 32'h0,        -1, 1'b0, 1'b1, 32'hDE55BEEF});
    tbl.push_back('{1, 1'b1, 32'h20,   4'hF, 32'hCAFEF00D, -1, 1'b0, 1'b0, 32'h0});
    tbl.push_back('{1, 1'b0, 32'h20,   4'hF, 32'h0,        -1, 1'b0, 1'b1, 32'hCAFEF00D});
    tbl.push_back('{1, 1'b1, 32'h20,   4'hF, 32'h12345678,  2, 1'b0, 1'b0, 32'h0});
    tbl.push_back('{1, 1'b0, 32'h20,   4'hF, 32'h0,        -1, 1'b0, 1'b1, 32'hCAFEF00D});
    tbl.push_back('{0, 1'b1, 32'h20,   4'hF, 32'h11112222, -1, 1'b0, 1'b0, 32'h0});
    tbl.push_back('{0, 1'b1, 32'h20,   4'hF, 32'h12345678,  1, 1'b0, 1'b0, 32'h0});
    tbl.push_back('{0, 1'b0, 32'h20,   4'hF, 32'h0,        -1, 1'b0, 1'b1, 32'h11112222});
    tbl.push_back('{0, 1'b1, 32'h0,    4'hF, 32'hA5A5A5A5, -1, 1'b0, 1'b0, 32'h0});
    tbl.push_back('{0, 1'b1, 32'h1000, 4'hF, 32'hFFFFFFFF, -1, 1'b1, 1'b0, 32'h0});
    tbl.push_back('{0, 1'b0, 32'h1000, 4'hF, 32'h0,        -1, 1'b1, 1'b1, 32'h0});
    tbl.push_back('{0, 1'b0, 32'h0,    4'hF, 32'h0,        -1, 1'b0, 1'b1, 32'hA5A5A5A5});
    tbl.push_back('{0, 1'b1, 32'h30,   4'hF, 32'h01020304, -1, 1'b0, 1'b0, 32'h0});
    foreach (tbl[i])
      access(tbl[i].d, tbl[i].w, tbl[i].a, tbl[i].s, tbl[i].v, tbl[i].abort_at,
             tbl[i].exp_err, tbl[i].chk_data, tbl[i].exp_d);

    // Reset landing on the RESP edge of a write: write dropped, outputs cleared
    @(negedge clk);
    ce[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h30; sel[0] = 4'hF; din[0] = 32'hFFFFFFFF;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rstmid_ready_resp", 32'(ready[0]), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("rstmid_ready", 32'(ready[0]), 32'd0);
    chk("rstmid_err", 32'(err[0]), 32'd0);
    chk("rstmid_data", dout[0], 32'd0);
    ce[0] = 1'b0;
    rst = 1'b0;
    access(0, 1'b0, 32'h30, 4'hF, 32'h0, -1, 1'b0, 1'b1, 32'h01020304);

    // Random accesses against the word-array model
    for (int n = 0; n < 80; n++) begin
      int          d;
      bit          w;
      logic [31:0] a;
      logic [3:0]  s;
      logic [31:0] v;
      int          ab;
      bit          e;
      int          idx;
      d = int'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      a = {25'd0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 7) == 0) a = a | (32'h1000 << $urandom_range(0, 19));
      s = 4'($urandom_range(0, 15));
      v = $urandom;
      ab = -1;
      if ($urandom_range(0, 7) == 0) ab = int'($urandom_range(1, (d == 0) ? 1 : 3));
      e = (a >> (AW + 2)) != 0;
      idx = int'(a[AW+1:2]);
      access(d, w, a, s, v, ab, e, e || known[d][idx], e ? 32'h0 : mdl[d][idx]);
    end
    @(negedge clk);
    ce[0] = 1'b0;
    ce[1] = 1'b0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
